// File: rtl/mine_pkg.sv
// mine_pkg: shared board geometry, LFSR taps and FSM states for the mine-map generator
package mine_pkg;
    localparam int MAP_W = 64;
    localparam int ROW_W = 8;
    localparam int IDX_W = 6;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [MAP_W-1:0] COL0 = {ROW_W{8'h01}};
    localparam logic [MAP_W-1:0] COL7 = {ROW_W{8'h80}};
    typedef enum logic [1:0] {IDLE, CLEAR, PLACE, LOAD} state_t;
endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11); a zero seed is forced to 1
module lfsr16
    import mine_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);
    always_ff @(posedge clk) begin
        if (reset) q <= (seed == 16'h0) ? 16'h0001 : seed;
        else q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0);
    end
endmodule

// File: rtl/mine_map_gen.sv
// mine_map_gen: places NUM_MINES distinct pseudo-random mines on an 8x8 map, avoiding the start cell.
// Define SAFE_ZONE_EN to also keep the 8 neighbours of the start cell clear.
module mine_map_gen
    import mine_pkg::*;
#(
    parameter int          NUM_MINES = 10,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [MAP_W-1:0] safe_pos,
    output logic             ld_mm,
    output logic [MAP_W-1:0] mm_out,
    output logic             busy,
    output logic             done
);
`ifdef SAFE_ZONE_EN
    localparam int MAX_MINES = 55;
`else
    localparam int MAX_MINES = 63;
`endif
    if (NUM_MINES < 0 || NUM_MINES > MAX_MINES) begin : g_bad_num_mines
        $error("mine_map_gen: NUM_MINES out of range");
    end
    localparam logic [IDX_W-1:0] N = IDX_W'(NUM_MINES);

    state_t state, state_n;
    logic [MAP_W-1:0] mm_n, excl, excl_n, excl_mask;
    logic [IDX_W-1:0] count, count_n, idx;
    logic [15:0] lfsr;
    logic [15:IDX_W] lfsr_unused;
    logic hit;

    lfsr16 u_lfsr (.clk(clk), .reset(reset), .seed(LFSR_SEED), .q(lfsr));

`ifdef SAFE_ZONE_EN
    logic [MAP_W-1:0] row_mask;
    // Horizontal spread masks the wrapped column, vertical shifts fall off the board naturally.
    assign row_mask = safe_pos | ((safe_pos << 1) & ~COL0) | ((safe_pos >> 1) & ~COL7);
    assign excl_mask = row_mask | (row_mask << ROW_W) | (row_mask >> ROW_W);
`else
    assign excl_mask = safe_pos;
`endif

    assign idx = lfsr[IDX_W-1:0];
    assign lfsr_unused = lfsr[15:IDX_W];
    assign hit = mm_out[idx] | excl[idx];
    assign ld_mm = (state == LOAD);
    assign done = (state == LOAD);
    assign busy = (state != IDLE);

    always_comb begin
        state_n = state;
        mm_n = mm_out;
        count_n = count;
        excl_n = excl;
        case (state)
            IDLE: state_n = start ? CLEAR : IDLE;
            CLEAR: begin
                mm_n = '0;
                count_n = '0;
                excl_n = excl_mask;
                state_n = (NUM_MINES == 0) ? LOAD : PLACE;
            end
            PLACE: begin
                if (!hit) begin
                    mm_n[idx] = 1'b1;
                    count_n = count + 1'b1;
                end
                state_n = (count_n == N) ? LOAD : PLACE;
            end
            LOAD: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            mm_out <= '0;
            count <= '0;
            excl <= '0;
        end else begin
            state <= state_n;
            mm_out <= mm_n;
            count <= count_n;
            excl <= excl_n;
        end
    end
endmodule

// File: tb/tb_mine_map_gen.sv
// tb_mine_map_gen: directed checks of map size, start-cell exclusion, latency, reset abort and back-to-back runs
module tb_mine_map_gen;
`ifdef SAFE_ZONE_EN
    localparam int FULL_N = 55;
`else
    localparam int FULL_N = 63;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [63:0] safe_pos = 64'h1;
    logic start_a = 1'b0, start_z = 1'b0, start_f = 1'b0;
    logic ld_a, ld_z, ld_f, busy_a, busy_z, busy_f, done_a, done_z, done_f;
    logic [63:0] mm_a, mm_z, mm_f, map1, prev, acc;
    int checks = 0, failures = 0, lat, n, changed;

    always #5 clk = ~clk;

    mine_map_gen #(.NUM_MINES(10)) u_dut (
        .clk(clk), .reset(reset), .start(start_a), .safe_pos(safe_pos),
        .ld_mm(ld_a), .mm_out(mm_a), .busy(busy_a), .done(done_a));
    mine_map_gen #(.NUM_MINES(0)) u_zero (
        .clk(clk), .reset(reset), .start(start_z), .safe_pos(safe_pos),
        .ld_mm(ld_z), .mm_out(mm_z), .busy(busy_z), .done(done_z));
    mine_map_gen #(.NUM_MINES(FULL_N)) u_full (
        .clk(clk), .reset(reset), .start(start_f), .safe_pos(safe_pos),
        .ld_mm(ld_f), .mm_out(mm_f), .busy(busy_f), .done(done_f));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic go_a(input logic [63:0] sp, output int l);
        safe_pos = sp;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        l = 1;
        while (!ld_a && l < 5000) begin
            @(negedge clk);
            l++;
        end
        check("ld_a_seen", 64'(ld_a), 64'h1);
    endtask

    task automatic go_f(input logic [63:0] sp);
        int l;
        safe_pos = sp;
        start_f = 1'b1;
        @(negedge clk);
        start_f = 1'b0;
        l = 1;
        while (!ld_f && l < 5000) begin
            @(negedge clk);
            l++;
        end
        check("ld_f_seen", 64'(ld_f), 64'h1);
        check("full_pop", 64'($countones(mm_f)), 64'(FULL_N));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ld", 64'(ld_a), 64'h0);
        check("rst_mm", mm_a, 64'h0);
        check("rst_busy", 64'(busy_a), 64'h0);
        check("rst_done", 64'(done_a), 64'h0);
        reset = 1'b0;
        @(negedge clk);

        safe_pos = 64'h1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("t1_busy", 64'(busy_a), 64'h1);
        lat = 1;
        while (!ld_a && lat < 5000) begin
            @(negedge clk);
            lat++;
        end
        check("t1_ld", 64'(ld_a), 64'h1);
        check("t1_done", 64'(done_a), 64'h1);
        check("t1_pop", 64'($countones(mm_a)), 64'd10);
        check("t1_safe", 64'(mm_a[0]), 64'h0);
        check("t1_lat", 64'(lat >= 12), 64'h1);
        map1 = mm_a;
        @(negedge clk);
        check("t1_after", {61'h0, ld_a, done_a, busy_a}, 64'h0);
        repeat (5) @(negedge clk);
        check("t1_hold", mm_a, map1);

        prev = map1;
        changed = 0;
        safe_pos = 64'h1;
        start_a = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            n = 0;
            while (!ld_a && n < 5000) begin
                @(negedge clk);
                n++;
            end
            check("b2b_ld", 64'(ld_a), 64'h1);
            if (!ld_a) break;
            check("b2b_pop", 64'($countones(mm_a)), 64'd10);
            check("b2b_safe", mm_a & safe_pos, 64'h0);
            check("b2b_done", 64'(done_a), 64'h1);
            if (mm_a != prev) changed++;
            prev = mm_a;
            safe_pos = 64'h1 << ((i + 1) % 64);
            @(negedge clk);
            check("b2b_gap", {62'h0, ld_a, busy_a}, 64'h0);
        end
        start_a = 1'b0;
        check("b2b_distinct", 64'(changed > 900), 64'h1);

        safe_pos = 64'h1;
        start_z = 1'b1;
        @(negedge clk);
        start_z = 1'b0;
        check("zero_busy", 64'(busy_z), 64'h1);
        check("zero_early", 64'(ld_z), 64'h0);
        @(negedge clk);
        check("zero_ld", 64'(ld_z), 64'h1);
        check("zero_done", 64'(done_z), 64'h1);
        check("zero_mm", mm_z, 64'h0);
        @(negedge clk);
        check("zero_after", {62'h0, ld_z, busy_z}, 64'h0);

        safe_pos = 64'h2;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("abort_busy", 64'(busy_a), 64'h1);
        repeat (2) @(negedge clk);
        check("abort_noload", 64'(ld_a), 64'h0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_mm", mm_a, 64'h0);
        check("abort_busy0", 64'(busy_a), 64'h0);
        check("abort_ld", {62'h0, ld_a, done_a}, 64'h0);
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("abort_idle", {62'h0, ld_a, busy_a}, 64'h0);
        end
        go_a(64'h8000_0000_0000_0000, lat);
        check("fresh_pop", 64'($countones(mm_a)), 64'd10);
        check("fresh_safe", 64'(mm_a[63]), 64'h0);
        @(negedge clk);

`ifdef SAFE_ZONE_EN
        go_f(64'h1 << 27);
        check("zone27", mm_f, ~64'h0000_001C_1C1C_0000);
        @(negedge clk);
        acc = '0;
        repeat (4) begin
            go_f(64'h1 << 7);
            check("zone7", mm_f & 64'h0000_0000_0000_C0C0, 64'h0);
            acc = acc | mm_f;
            @(negedge clk);
        end
        check("zone7_edge", acc & 64'h101, 64'h101);
`else
        go_f(64'h1 << 27);
        check("full27", mm_f, ~(64'h1 << 27));
        @(negedge clk);
        go_f(64'h1 << 7);
        check("full7", mm_f, ~(64'h1 << 7));
        @(negedge clk);
        go_f(64'h0);
        check("full_nosafe", 64'($countones(mm_f & ~64'h0)), 64'd63);
        @(negedge clk);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
